// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the shared SRAM and mem_port_arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface mem_port_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_valid;
    logic        inst_stall;

    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_sel;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_valid;
    logic        data_stall;

    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    modport slave (
        input  inst_req, inst_addr,
        output inst_rdata, inst_valid, inst_stall,
        input  data_req, data_wr, data_sel, data_addr, data_wdata,
        output data_rdata, data_valid, data_stall,
        output sram_en, sram_wen, sram_addr, sram_wdata,
        input  sram_rdata
    );

    modport master (
        output inst_req, inst_addr,
        input  inst_rdata, inst_valid, inst_stall,
        output data_req, data_wr, data_sel, data_addr, data_wdata,
        input  data_rdata, data_valid, data_stall,
        input  sram_en, sram_wen, sram_addr, sram_wdata,
        output sram_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-cycle SRAM port between instruction fetch and data access.
// Define ARB_RDATA_HOLD_EN to keep each requester's read data stable between its valid pulses.
module mem_port_arbiter (
    input  logic                     clk,
    input  logic                     rst,
    mem_port_arbiter_if.slave        bus,
    output logic [15:0]              conflict_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;
    typedef enum logic {OWNER_INST, OWNER_DATA} owner_t;

    state_t state;
    state_t state_nxt;
    owner_t last_grant;
    logic   run;
    logic   inst_elig;
    logic   data_elig;
    logic   grant_inst;
    logic   grant_data;
    logic   conflict;

    // run holds off grants until the first rising edge that sees reset released.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            last_grant   <= OWNER_DATA;
            run          <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            run   <= 1'b1;
            state <= state_nxt;
            if (grant_inst) begin
                last_grant <= OWNER_INST;
            end else if (grant_data) begin
                last_grant <= OWNER_DATA;
            end
            if (conflict && (conflict_cnt != 16'hFFFF)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end

    // NOTE: every signal gets a default first so no path through the block can infer a latch.
    always_comb begin
        inst_elig      = 1'b0;
        data_elig      = 1'b0;
        grant_inst     = 1'b0;
        grant_data     = 1'b0;
        conflict       = 1'b0;
        state_nxt      = IDLE;
        bus.sram_en    = 1'b0;
        bus.sram_wen   = 4'b0000;
        bus.sram_addr  = '0;
        bus.sram_wdata = '0;

        // A requester completing this cycle is still presenting its old request.
        inst_elig  = run && bus.inst_req && (state != WAIT_I);
        data_elig  = run && bus.data_req && (state != WAIT_D);
        grant_inst = inst_elig && (!data_elig || (last_grant == OWNER_DATA));
        grant_data = data_elig && !grant_inst;
        conflict   = bus.inst_req && bus.data_req && (grant_inst || grant_data);

        if (grant_inst) begin
            state_nxt     = WAIT_I;
            bus.sram_en   = 1'b1;
            bus.sram_addr = bus.inst_addr;
        end else if (grant_data) begin
            state_nxt      = WAIT_D;
            bus.sram_en    = 1'b1;
            bus.sram_addr  = bus.data_addr;
            bus.sram_wen   = bus.data_wr ? bus.data_sel : 4'b0000;
            bus.sram_wdata = bus.data_wdata;
        end
    end

    assign bus.inst_valid = (state == WAIT_I);
    assign bus.data_valid = (state == WAIT_D);
    assign bus.inst_stall = bus.inst_req && !bus.inst_valid;
    assign bus.data_stall = bus.data_req && !bus.data_valid;

`ifdef ARB_RDATA_HOLD_EN
    logic [31:0] inst_hold;
    logic [31:0] data_hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_hold <= '0;
            data_hold <= '0;
        end else begin
            if (bus.inst_valid) begin
                inst_hold <= bus.sram_rdata;
            end
            if (bus.data_valid) begin
                data_hold <= bus.sram_rdata;
            end
        end
    end

    // The live SRAM word is forwarded during the valid cycle so hold mode adds no latency.
    assign bus.inst_rdata = bus.inst_valid ? bus.sram_rdata : inst_hold;
    assign bus.data_rdata = bus.data_valid ? bus.sram_rdata : data_hold;
`else
    assign bus.inst_rdata = bus.inst_valid ? bus.sram_rdata : '0;
    assign bus.data_rdata = bus.data_valid ? bus.sram_rdata : '0;
`endif

endmodule
